id_regread_stage: RTL and testbench
===================================

// Module: id_regread_stage
// PURPOSE
// Register-read end of the writeback interface: owns the architectural register file, accepts
// WB-stage writes, and reads rs1/rs2 for the instruction issuing from decode into a registered
// ID/EX output slot. A per-register busy scoreboard stalls RAW/WAW hazards; a same-cycle WB write
// is bypassed into the read. Sits between decode and EX in the 5-stage core.
// PARAMETERS
// XLEN   32  data width of each register
// NREG   32  number of architectural registers; x0 reads as zero
// AW     5   register index width, equal to $clog2(NREG)
// PORTS
// clk            in   1     core clock; all state updates on rising edge
// reset_n        in   1     asynchronous, active-low reset
// id_valid       in   1     decode presents an instruction
// id_rs1         in   AW    source register 1 index
// id_rs2         in   AW    source register 2 index
// id_rd          in   AW    destination register index
// id_regwrite    in   1     instruction writes id_rd
// id_ready       out  1     slot accepts the instruction this cycle
// wb_regwrite    in   1     WB write enable
// wb_rd          in   AW    WB destination index
// wb_data        in   XLEN  WB write data (MemtoReg mux already applied upstream)
// ex_ready       in   1     EX consumes the output slot
// flush          in   1     kill the held output entry
// ex_valid       out  1     output slot holds an instruction
// ex_rs1_data    out  XLEN  rs1 operand
// ex_rs2_data    out  XLEN  rs2 operand
// ex_rd          out  AW    destination index
// ex_regwrite    out  1     destination write flag
// BEHAVIOUR
// - Reset (reset_n low, async): all registers = 0, all busy bits = 0, ex_valid = 0, ex_* = 0.
// - Write: on clk, if wb_regwrite && wb_rd != 0, regfile[wb_rd] <= wb_data. Writes to x0 are dropped.
// - Read: x0 -> 0; if wb_regwrite && wb_rd == rsN && rsN != 0, use wb_data (bypass); else regfile[rsN].
// - Hazard: busy[rs1] | busy[rs2] | (id_regwrite & busy[id_rd]), each term masked when the index is 0,
//   and masked when the same cycle's WB write targets that index (the write clears it).
// - id_ready = (!ex_valid | ex_ready) & !hazard & !flush. id_ready depends combinationally on id_* inputs.
// - Issue = id_valid & id_ready. Next cycle: ex_valid=1, ex_* = read operands, id_rd, id_regwrite.
//   Latency: one cycle from issue to ex_valid.
// - ex_valid & !ex_ready & !flush: all ex_* held stable. ex_ready & no issue: ex_valid <= 0.
// - Scoreboard: WB write with wb_rd != 0 clears busy[wb_rd]. Issue with id_regwrite & id_rd != 0
//   sets busy[id_rd]. Same cycle, same index: set wins.
// - Flush: ex_valid <= 0 next cycle. If ex_valid & ex_regwrite & ex_rd != 0, busy[ex_rd] is cleared.
//   No issue occurs in the flush cycle.
// - Held operands never go stale. Their sources were not busy at issue, and nothing younger issues
//   while the slot is held.
// - Reset asserted mid-stall or mid-flush: immediate return to the reset state.
//   Any in-flight WB write is lost.
// TESTING
// 1. Reset, then issue rs1=1, rs2=31 -> ex_rs1_data=0, ex_rs2_data=0, ex_valid=1 one cycle later.
// 2. WB write x5=0xDEADBEEF in the same cycle as issue with rs1=5 -> ex_rs1_data=0xDEADBEEF next cycle.
// 3. WB write x0=0x1234, then read rs1=0 -> 0. Issue rd=0 regwrite=1 -> busy stays clear, no stall.
// 4. Issue rd=7 regwrite, then rs2=7 -> id_ready=0. When WB writes x7=0x55, the instruction issues
//    that cycle and ex_rs2_data=0x55.
// 5. Hold ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0. ex_ready=1 -> next issues.
// 6. Held entry rd=9 regwrite, flush=1 -> ex_valid=0 next cycle, busy[9]=0.
//    An instruction reading x9 issues the following cycle.

Source files
------------

// File: rtl/id_regread_stage.sv
// ---------------------------------------------------------------------------
// id_regread_stage
//
// Register-read stage between decode and EX in the 5-stage core. It owns the
// architectural register file, takes writeback-stage writes, and reads
// rs1/rs2 for the instruction leaving decode into a registered ID/EX slot.
//
// A busy bit per register marks destinations that are still in flight. An
// instruction stalls if either of its sources is busy (RAW) or its destination
// is busy (WAW). A writeback in the same cycle is bypassed into the operand
// read and also lifts that register's stall.
//
// Parameters
//   XLEN  data width of each register
//   NREG  number of architectural registers (x0 hard-wired to zero)
//   AW    register index width, $clog2(NREG)
//
// Ports
//   clk, reset_n            core clock, asynchronous active-low reset
//   id_valid                decode presents an instruction
//   id_rs1, id_rs2, id_rd   source / destination indices
//   id_regwrite             instruction writes id_rd
//   id_ready                slot accepts the instruction this cycle
//                           (combinational in the id_* inputs)
//   wb_regwrite, wb_rd,
//   wb_data                 writeback port
//   ex_ready                EX consumes the output slot
//   flush                   kill the held output entry
//   ex_valid                output slot holds an instruction
//   ex_rs1_data,
//   ex_rs2_data             captured operands
//   ex_rd, ex_regwrite      destination index and write flag
// ---------------------------------------------------------------------------
module id_regread_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_regwrite,
    output logic            id_ready,

    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,

    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_regwrite
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;

    logic            ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [AW-1:0]   ex_rd_q,       ex_rd_d;
    logic            ex_regwrite_q, ex_regwrite_d;

    // Effective writeback: writes to x0 are discarded everywhere.
    logic wb_we;
    assign wb_we = wb_regwrite && (wb_rd != '0);

    // A register blocks issue if it is in flight, unless it is x0 or the
    // writeback landing this cycle retires it.
    function automatic logic reg_blocked(
        input logic [AW-1:0]   idx,
        input logic [NREG-1:0] busy_vec,
        input logic            we,
        input logic [AW-1:0]   we_idx
    );
        logic blk;
        blk = busy_vec[idx];
        if (idx == '0)
            blk = 1'b0;
        if (we && (we_idx == idx))
            blk = 1'b0;
        return blk;
    endfunction

    // -----------------------------------------------------------------------
    // Operand read with writeback bypass
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = rf_q[id_rs1];
        if (wb_we && (wb_rd == id_rs1))
            rs1_val = wb_data;
        if (id_rs1 == '0)
            rs1_val = '0;

        rs2_val = rf_q[id_rs2];
        if (wb_we && (wb_rd == id_rs2))
            rs2_val = wb_data;
        if (id_rs2 == '0)
            rs2_val = '0;
    end

    // -----------------------------------------------------------------------
    // Hazard detection and handshake
    // -----------------------------------------------------------------------
    logic hazard;
    logic slot_free;
    logic issue;

    always_comb begin
        hazard = reg_blocked(id_rs1, busy_q, wb_we, wb_rd)
               | reg_blocked(id_rs2, busy_q, wb_we, wb_rd)
               | (id_regwrite & reg_blocked(id_rd, busy_q, wb_we, wb_rd));
    end

    assign slot_free = !ex_valid_q || ex_ready;
    // flush is folded into id_ready so nothing can issue in the kill cycle.
    assign id_ready  = slot_free && !hazard && !flush;
    assign issue     = id_valid && id_ready;

    // -----------------------------------------------------------------------
    // Scoreboard next state
    // Clears are applied before the set so that an issue claiming the same
    // register as a retiring writeback leaves it busy.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wb_we)
            busy_d[wb_rd] = 1'b0;
        // A flushed entry will never reach writeback; release its claim.
        if (flush && ex_valid_q && ex_regwrite_q && (ex_rd_q != '0))
            busy_d[ex_rd_q] = 1'b0;
        if (issue && id_regwrite && (id_rd != '0))
            busy_d[id_rd] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // ID/EX slot next state
    // -----------------------------------------------------------------------
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_rd_d       = ex_rd_q;
        ex_regwrite_d = ex_regwrite_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d    = 1'b1;
            ex_rs1_data_d = rs1_val;
            ex_rs2_data_d = rs2_val;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        // Otherwise the slot is held: payload stays put. Its operands cannot
        // go stale because their sources were not busy at issue and nothing
        // younger issues while the slot is occupied.
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q        <= '0;
            ex_valid_q    <= 1'b0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            ex_valid_q    <= ex_valid_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regwrite = ex_regwrite_q;

endmodule

// File: tb/tb_id_regread_stage.sv
// ---------------------------------------------------------------------------
// tb_id_regread_stage
//
// Directed scenarios followed by randomized traffic. A behavioural model
// (register array, in-flight set, one-entry slot) predicts id_ready every
// cycle and the ID/EX slot contents after every clock edge.
// ---------------------------------------------------------------------------
module tb_id_regread_stage;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset_n;
    logic            id_valid;
    logic [AW-1:0]   id_rs1, id_rs2, id_rd;
    logic            id_regwrite;
    logic            id_ready;
    logic            wb_regwrite;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_ready;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data;
    logic [AW-1:0]   ex_rd;
    logic            ex_regwrite;

    id_regread_stage #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_ready    (id_ready),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_ready    (ex_ready),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_reg  [NREG];
    bit          m_busy [NREG];
    bit          m_v;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    bit          m_rw;
    bit          obs_ready;

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_v  = 1'b0;
        m_a  = '0;
        m_b  = '0;
        m_rd = '0;
        m_rw = 1'b0;
    endfunction

    // Is register idx still waiting on an older writer, given this cycle's WB?
    function automatic bit m_blk(input logic [4:0] idx, input bit we, input logic [4:0] wrd);
        if (idx == 0) return 1'b0;
        if (we && wrd == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    function automatic logic [31:0] m_val(input logic [4:0] idx, input bit we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (we && wrd == idx) return wd;
        return m_reg[idx];
    endfunction

    // One clock of stimulus: drive on the falling edge, check id_ready,
    // advance the model at the rising edge, then check the slot.
    task automatic cycle(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit rw,
                         input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                         input bit exr, input bit fl);
        bit          exp_rdy, iss;
        logic [31:0] a, b;
        @(negedge clk);
        id_valid = v;   id_rs1 = r1;    id_rs2 = r2;  id_rd = rd; id_regwrite = rw;
        wb_regwrite = we; wb_rd = wrd;  wb_data = wd;
        ex_ready = exr; flush = fl;
        #1;
        exp_rdy = (!m_v || exr) && !fl && !m_blk(r1, we, wrd) && !m_blk(r2, we, wrd)
                  && !(rw && m_blk(rd, we, wrd));
        obs_ready = id_ready;
        chk("id_ready", id_ready, exp_rdy);
        a   = m_val(r1, we, wrd, wd);
        b   = m_val(r2, we, wrd, wd);
        iss = v && exp_rdy;
        @(posedge clk);
        if (we && wrd != 0) begin
            m_reg[wrd]  = wd;
            m_busy[wrd] = 1'b0;
        end
        if (fl && m_v && m_rw && m_rd != 0) m_busy[m_rd] = 1'b0;
        if (iss && rw && rd != 0) m_busy[rd] = 1'b1;
        if (fl) m_v = 1'b0;
        else if (iss) begin
            m_v = 1'b1; m_a = a; m_b = b; m_rd = rd; m_rw = rw;
        end else if (exr) m_v = 1'b0;
        #1;
        chk("ex_valid", ex_valid, m_v);
        if (m_v) begin
            chk("ex_rs1_data", ex_rs1_data, m_a);
            chk("ex_rs2_data", ex_rs2_data, m_b);
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_regwrite", ex_regwrite, m_rw);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        id_valid = 0; wb_regwrite = 0; ex_ready = 0; flush = 0;
        #1;
        chk("rst ex_valid", ex_valid, 1'b0);
        chk("rst ex_rs1_data", ex_rs1_data, 32'h0);
        chk("rst ex_rs2_data", ex_rs2_data, 32'h0);
        chk("rst ex_rd", ex_rd, 5'h0);
        chk("rst ex_regwrite", ex_regwrite, 1'b0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [4:0] busy_list [$];
        bit         v, rw, we, exr, fl;
        logic [4:0] r1, r2, rd, wrd;
        logic [31:0] wd;

        reset_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_regwrite = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0; ex_ready = 0; flush = 0;
        m_reset();
        do_reset();

        // 1: fresh registers read as zero, one-cycle latency
        cycle(1, 5'd1, 5'd31, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        chk("t1 ex_valid", ex_valid, 1'b1);
        chk("t1 rs1", ex_rs1_data, 32'h0);
        chk("t1 rs2", ex_rs2_data, 32'h0);

        // 2: same-cycle writeback bypass
        cycle(1, 5'd5, 5'd0, 5'd0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 0);
        chk("t2 bypass", ex_rs1_data, 32'hDEADBEEF);

        // 3: x0 writes dropped, x0 destination never marked busy
        cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 32'h1234, 1, 0);
        cycle(1, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        chk("t3 x0 read", ex_rs1_data, 32'h0);
        cycle(1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 32'h0, 1, 0);
        cycle(1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 32'h0, 1, 0);
        chk("t3 x0 no stall", obs_ready, 1'b1);

        // 4: RAW stall released by the writeback, value bypassed in
        cycle(1, 5'd0, 5'd0, 5'd7, 1, 0, 5'd0, 32'h0, 1, 0);
        cycle(1, 5'd0, 5'd7, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        chk("t4 stall", obs_ready, 1'b0);
        cycle(1, 5'd0, 5'd7, 5'd0, 0, 1, 5'd7, 32'h55, 1, 0);
        chk("t4 release", obs_ready, 1'b1);
        chk("t4 rs2", ex_rs2_data, 32'h55);

        // 5: back-pressure holds the slot; a WB to its source does not disturb it
        cycle(1, 5'd5, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 5'd5, 5'd0, 5'd0, 0, 1, 5'd5, 32'hA5A5, 0, 0);
            chk("t5 hold ready", obs_ready, 1'b0);
            chk("t5 hold valid", ex_valid, 1'b1);
            chk("t5 hold rs1", ex_rs1_data, 32'hDEADBEEF);
        end
        cycle(1, 5'd5, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        chk("t5 resume", obs_ready, 1'b1);
        chk("t5 new rs1", ex_rs1_data, 32'hA5A5);

        // 6: flush of a held writer releases its destination
        cycle(1, 5'd0, 5'd0, 5'd9, 1, 0, 5'd0, 32'h0, 1, 0);
        cycle(1, 5'd9, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 0, 1);
        chk("t6 no issue on flush", obs_ready, 1'b0);
        chk("t6 killed", ex_valid, 1'b0);
        cycle(1, 5'd9, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        chk("t6 x9 issues", obs_ready, 1'b1);

        // Reset in the middle of a stall clears scoreboard and registers
        cycle(1, 5'd0, 5'd0, 5'd3, 1, 0, 5'd0, 32'h0, 1, 0);
        cycle(1, 5'd3, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 0, 0);
        chk("rs stall", obs_ready, 1'b0);
        do_reset();
        cycle(1, 5'd3, 5'd5, 5'd0, 0, 0, 5'd0, 32'h0, 1, 0);
        chk("rs ready", obs_ready, 1'b1);
        chk("rs x5 cleared", ex_rs2_data, 32'h0);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            busy_list.delete();
            for (int i = 1; i < NREG; i++)
                if (m_busy[i]) busy_list.push_back(5'(i));
            v   = ($urandom_range(0, 99) < 75);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            rw  = ($urandom_range(0, 99) < 60);
            we  = ($urandom_range(0, 99) < 50);
            if (busy_list.size() > 0 && $urandom_range(0, 1) == 1)
                wrd = busy_list[$urandom_range(0, busy_list.size() - 1)];
            else
                wrd = 5'($urandom_range(0, 7));
            wd  = $urandom;
            exr = ($urandom_range(0, 99) < 70);
            fl  = ($urandom_range(0, 99) < 5);
            cycle(v, r1, r2, rd, rw, we, wrd, wd, exr, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
